mconst_builder: RTL and testbench
=================================

Name: mconst_builder

Overview:
Parametrised, handshaked successor to the combinational immediate extender in the emulator mblock library. It accepts IN_WIDTH-bit instruction immediates and produces an OUT_WIDTH-bit constant in one of four modes: zero-extend, sign-extend, load-high, or multi-chunk append. It sits between instruction decode and the operand mux. The output is registered behind a one-entry valid/ready buffer.

Parameters:
IN_WIDTH, 16, width of an immediate chunk (>=1, <=OUT_WIDTH)
OUT_WIDTH, 32, width of the produced constant; must be a multiple of IN_WIDTH
MAX_CHUNKS, OUT_WIDTH/IN_WIDTH, derived; the number of append chunks that fill the output exactly

Ports:
clk  input  1  sole clock, rising edge
reset_n  input  1  reset; one clock, synchronous, active-low
in_valid  input  1  an immediate chunk is offered
in_ready  output  1  the block accepts the chunk this cycle
in  input  IN_WIDTH  immediate chunk
mode  input  2  00 ZEXT, 01 SEXT, 10 HIGH, 11 APPEND
last  input  1  APPEND only: this chunk completes the constant
out_valid  output  1  the constant is available
out_ready  input  1  the consumer takes the constant
out  output  OUT_WIDTH  the constant
overflow  output  1  qualifies out: APPEND received more than MAX_CHUNKS chunks
err  output  1  qualifies out: a partial APPEND was aborted by a non-APPEND chunk

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, acc=0, count=0, out=0, out_valid=0, overflow=0, err=0. Any partial accumulation is discarded.
- Accept: a chunk is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, so accept and drain can happen in the same cycle. in_ready does not depend on in_valid.
- States: IDLE (no partial constant), ACCUM (APPEND in progress), and an output buffer that is either FULL or EMPTY.
- ZEXT: out = {0, in}.
- SEXT: out = in replicated from in[IN_WIDTH-1] into the upper bits.
- HIGH: out = in << (OUT_WIDTH-IN_WIDTH); the low bits are 0.
- Latency for ZEXT, SEXT and HIGH: out_valid=1 on the edge after accept. The state stays IDLE.
- APPEND in IDLE: acc <= {0, in}, count <= 1.
  - If last=1, out <= {0, in} and out_valid is set next cycle.
  - If last=0, the state moves to ACCUM.
- APPEND in ACCUM: acc <= {acc[OUT_WIDTH-IN_WIDTH-1:0], in}, count <= sat(count+1). The first chunk ends up most significant.
  - If last=1, out <= the new acc, out_valid is set, and the state returns to IDLE.
- Overflow: when an APPEND completes after more than MAX_CHUNKS chunks, overflow=1 with that output. out holds the most recent MAX_CHUNKS chunks. count saturates at MAX_CHUNKS+1.
- Abort: a ZEXT/SEXT/HIGH chunk accepted in ACCUM discards acc and produces its own single-shot result with err=1. The state returns to IDLE.
- Flags: overflow and err are valid only with out_valid and are reloaded on every output write. They are 0 for normal results.
- Output hold: while out_valid && !out_ready, out, overflow and err stay stable. in_ready=0, so ACCUM progress also stalls.
- Drain: out_valid falls on the edge after out_ready=1 unless a new result is loaded that same edge, in which case out_valid stays 1 and the data is replaced.
- Non-APPEND chunks: last is ignored.
- IN_WIDTH==OUT_WIDTH: every APPEND fills the output. A second chunk without last keeps only the newest chunk and flags overflow when completed.
- Reset mid-ACCUM or with a full output: everything clears. No output is emitted for the lost data.

Test Plan:
- Default params, ZEXT in=16'h2F12, out_ready=1 -> one cycle later out=32'h00002F12, out_valid=1, flags 0.
- SEXT 16'h9618 -> 32'hFFFF9618; ZEXT 16'h9618 -> 32'h00009618; HIGH 16'h9618 -> 32'h96180000.
- APPEND 16'hDEAD (last=0) then 16'hBEEF (last=1) -> out=32'hDEADBEEF, overflow=0. Three chunks 1111/2222/3333 (last on the third) -> out=32'h22223333, overflow=1.
- Backpressure: out_ready=0 after ZEXT 16'h0001, next chunk offered -> in_ready=0 and out stays 32'h00000001. Raise out_ready -> the pending chunk is accepted the same cycle and the new result appears on the following edge with no lost or duplicated output.
- Abort: APPEND 16'hAAAA (last=0) then SEXT 16'h8000 -> out=32'hFFFF8000, err=1. The next ZEXT 16'h0005 -> out=32'h00000005, err=0.
- Reset mid-ACCUM: APPEND 16'h1234 (last=0), reset_n=0 for one edge, then APPEND 16'h5678 last=1 -> out=32'h00005678, out_valid=0 during reset. Repeat with IN_WIDTH=8, OUT_WIDTH=24: chunks 12/34/56 -> 24'h123456.

Source files
------------

// File: rtl/mconst_if.sv
// mconst_if: valid/ready bundle between instruction decode and the constant
// builder, and between the builder and the operand mux.
//   in_valid/in_ready/in/mode/last : immediate chunk offered by decode
//   out_valid/out_ready/out        : finished constant towards the operand mux
//   overflow/err                   : qualifiers of out, meaningful with out_valid
// master = decode/consumer side, slave = mconst_builder.
interface mconst_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in;
  logic [1:0]           mode;
  logic                 last;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 overflow;
  logic                 err;

  modport master (
    output in_valid, in, mode, last, out_ready,
    input  in_ready, out_valid, out, overflow, err
  );

  modport slave (
    input  in_valid, in, mode, last, out_ready,
    output in_ready, out_valid, out, overflow, err
  );
endinterface

// File: rtl/mconst_builder.sv
// mconst_builder: builds an OUT_WIDTH-bit constant from IN_WIDTH-bit
// immediate chunks. Modes: 00 zero-extend, 01 sign-extend, 10 load-high,
// 11 multi-chunk append (first chunk most significant, last=1 completes).
// The result sits in a one-entry output buffer with valid/ready handshake.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : mconst_if slave modport (chunk input, constant output, flags)
module mconst_builder #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input logic      clk,
  input logic      reset_n,
  mconst_if.slave  bus
);
  localparam int MAX_CHUNKS = OUT_WIDTH / IN_WIDTH;
  localparam int CNT_W      = $clog2(MAX_CHUNKS + 2);

  localparam logic [1:0] M_ZEXT   = 2'b00;
  localparam logic [1:0] M_SEXT   = 2'b01;
  localparam logic [1:0] M_HIGH   = 2'b10;
  localparam logic [1:0] M_APPEND = 2'b11;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state, state_nxt;
  logic [OUT_WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [OUT_WIDTH-1:0] out_q, res;
  logic                 vld, vld_nxt;
  logic                 ovf_q, ovf_nxt;
  logic                 err_q, err_nxt;
  logic                 load;
  logic                 accept;
  logic [OUT_WIDTH-1:0] shifted;

  function automatic logic [OUT_WIDTH-1:0] ext_zero(input logic [IN_WIDTH-1:0] v);
    return OUT_WIDTH'(v);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] ext_sign(input logic [IN_WIDTH-1:0] v);
    logic signed [IN_WIDTH-1:0]  s;
    logic signed [OUT_WIDTH-1:0] r;
    s = v;
    r = OUT_WIDTH'(s);
    return r;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] ext_high(input logic [IN_WIDTH-1:0] v);
    return ext_zero(v) << (OUT_WIDTH - IN_WIDTH);
  endfunction

  // Counts one past MAX_CHUNKS so a completed append can tell it overflowed.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_CHUNKS + 1)) return c;
    return c + CNT_W'(1);
  endfunction

  assign bus.in_ready  = !vld || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = vld;
  assign bus.out       = out_q;
  assign bus.overflow  = ovf_q;
  assign bus.err       = err_q;

  // Shifting by IN_WIDTH also covers IN_WIDTH==OUT_WIDTH, where only the
  // newest chunk survives.
  assign shifted = (acc << IN_WIDTH) | ext_zero(bus.in);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    res       = out_q;
    ovf_nxt   = ovf_q;
    err_nxt   = err_q;
    load      = 1'b0;
    if (accept) begin
      if (bus.mode == M_APPEND) begin
        if (state == IDLE) begin
          acc_nxt = ext_zero(bus.in);
          cnt_nxt = CNT_W'(1);
          if (bus.last) begin
            load    = 1'b1;
            res     = ext_zero(bus.in);
            ovf_nxt = 1'b0;
            err_nxt = 1'b0;
          end else begin
            state_nxt = ACCUM;
          end
        end else begin
          acc_nxt = shifted;
          cnt_nxt = sat_inc(cnt);
          if (bus.last) begin
            load      = 1'b1;
            res       = shifted;
            ovf_nxt   = (cnt_nxt > CNT_W'(MAX_CHUNKS));
            err_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end else begin
        // Single-shot modes; one arriving mid-append aborts it.
        load      = 1'b1;
        ovf_nxt   = 1'b0;
        err_nxt   = (state == ACCUM);
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
        case (bus.mode)
          M_ZEXT:  res = ext_zero(bus.in);
          M_SEXT:  res = ext_sign(bus.in);
          M_HIGH:  res = ext_high(bus.in);
          default: res = ext_zero(bus.in);
        endcase
      end
    end
    if (load)               vld_nxt = 1'b1;
    else if (bus.out_ready) vld_nxt = 1'b0;
    else                    vld_nxt = vld;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      out_q <= '0;
      vld   <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      vld   <= vld_nxt;
      if (load) begin
        out_q <= res;
        ovf_q <= ovf_nxt;
        err_q <= err_nxt;
      end
    end
  end
endmodule

// File: tb/tb_mconst_builder.sv
module tb_mconst_builder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mconst_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) bus0();
  mconst_if #(.IN_WIDTH(8),  .OUT_WIDTH(24)) bus1();

  mconst_builder #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  mconst_builder #(.IN_WIDTH(8), .OUT_WIDTH(24)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  localparam logic [1:0] ZEXT = 2'b00, SEXT = 2'b01, HIGH = 2'b10, APND = 2'b11;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [1:0] m, input logic [15:0] d,
                        input logic l, input logic r);
    bus0.in_valid = v; bus0.mode = m; bus0.in = d; bus0.last = l; bus0.out_ready = r;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic l);
    bus1.in_valid = v; bus1.mode = APND; bus1.in = d; bus1.last = l; bus1.out_ready = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] din;
    logic        last;
    logic        exp_vld;
    logic [31:0] exp_out;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t vt[13];

  // Reference model state for the random phase
  logic [15:0] chq[$];
  bit          m_full;
  logic [31:0] m_out;
  bit          m_ovf, m_err;

  initial begin
    vt[0]  = '{ZEXT, 16'h2F12, 1'b0, 1'b1, 32'h00002F12, 1'b0, 1'b0};
    vt[1]  = '{SEXT, 16'h9618, 1'b0, 1'b1, 32'hFFFF9618, 1'b0, 1'b0};
    vt[2]  = '{ZEXT, 16'h9618, 1'b0, 1'b1, 32'h00009618, 1'b0, 1'b0};
    vt[3]  = '{HIGH, 16'h9618, 1'b0, 1'b1, 32'h96180000, 1'b0, 1'b0};
    vt[4]  = '{APND, 16'hDEAD, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[5]  = '{APND, 16'hBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[6]  = '{APND, 16'h1111, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[7]  = '{APND, 16'h2222, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[8]  = '{APND, 16'h3333, 1'b1, 1'b1, 32'h22223333, 1'b1, 1'b0};
    vt[9]  = '{APND, 16'hAAAA, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
    vt[10] = '{SEXT, 16'h8000, 1'b0, 1'b1, 32'hFFFF8000, 1'b0, 1'b1};
    vt[11] = '{ZEXT, 16'h0005, 1'b0, 1'b1, 32'h00000005, 1'b0, 1'b0};
    vt[12] = '{HIGH, 16'h0001, 1'b1, 1'b1, 32'h00010000, 1'b0, 1'b0};

    drive0(1'b0, ZEXT, 16'h0, 1'b0, 1'b1);
    drive1(1'b0, 8'h0, 1'b0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_out",       bus0.out, 0);
    check("rst_overflow",  bus0.overflow, 0);
    check("rst_err",       bus0.err, 0);
    check("rst_in_ready",  bus0.in_ready, 1);
    reset_n = 1'b1;

    // Table-driven single chunks, consumer always ready
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive0(1'b1, vt[i].mode, vt[i].din, vt[i].last, 1'b1);
      #1 check($sformatf("tbl%0d_in_ready", i), bus0.in_ready, 1);
      @(negedge clk);
      bus0.in_valid = 1'b0;
      check($sformatf("tbl%0d_out_valid", i), bus0.out_valid, vt[i].exp_vld);
      if (vt[i].exp_vld) begin
        check($sformatf("tbl%0d_out", i),      bus0.out, vt[i].exp_out);
        check($sformatf("tbl%0d_overflow", i), bus0.overflow, vt[i].exp_ovf);
        check($sformatf("tbl%0d_err", i),      bus0.err, vt[i].exp_err);
      end
    end

    // Backpressure: held output, stalled input, same-cycle drain+accept
    @(negedge clk);
    drive0(1'b1, ZEXT, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    drive0(1'b1, ZEXT, 16'h0002, 1'b0, 1'b0);
    #1;
    check("bp_in_ready_low", bus0.in_ready, 0);
    check("bp_out_valid",    bus0.out_valid, 1);
    check("bp_out_held",     bus0.out, 32'h00000001);
    @(negedge clk);
    check("bp_out_held2",    bus0.out, 32'h00000001);
    check("bp_in_ready_low2", bus0.in_ready, 0);
    bus0.out_ready = 1'b1;
    #1 check("bp_in_ready_high", bus0.in_ready, 1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check("bp_new_valid", bus0.out_valid, 1);
    check("bp_new_out",   bus0.out, 32'h00000002);
    @(negedge clk);
    check("bp_no_dup",    bus0.out_valid, 0);

    // Reset mid-ACCUM
    @(negedge clk);
    drive0(1'b1, APND, 16'h1234, 1'b0, 1'b1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rstacc_out_valid", bus0.out_valid, 0);
    reset_n = 1'b1;
    drive0(1'b1, APND, 16'h5678, 1'b1, 1'b1);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    check("rstacc_valid",    bus0.out_valid, 1);
    check("rstacc_out",      bus0.out, 32'h00005678);
    check("rstacc_overflow", bus0.overflow, 0);

    // Reset with a full, stalled output
    drive0(1'b1, HIGH, 16'h00FF, 1'b0, 1'b0);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("rstfull_out_valid", bus0.out_valid, 0);
    check("rstfull_out",       bus0.out, 0);
    reset_n = 1'b1;
    bus0.out_ready = 1'b1;

    // Narrow configuration: 8-bit chunks into 24 bits
    @(negedge clk); drive1(1'b1, 8'h12, 1'b0);
    @(negedge clk); drive1(1'b1, 8'h34, 1'b0);
    @(negedge clk); drive1(1'b1, 8'h56, 1'b1);
    @(negedge clk); drive1(1'b0, 8'h00, 1'b0);
    check("w24_valid",    bus1.out_valid, 1);
    check("w24_out",      bus1.out, 24'h123456);
    check("w24_overflow", bus1.overflow, 0);
    @(negedge clk); drive1(1'b1, 8'h11, 1'b0);
    @(negedge clk); drive1(1'b1, 8'h22, 1'b0);
    @(negedge clk); drive1(1'b1, 8'h33, 1'b0);
    @(negedge clk); drive1(1'b1, 8'h44, 1'b1);
    @(negedge clk); drive1(1'b0, 8'h00, 1'b0);
    check("w24_ovf_out",  bus1.out, 24'h223344);
    check("w24_ovf_flag", bus1.overflow, 1);

    // Randomized traffic against the reference model
    @(negedge clk);
    bus0.in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chq.delete();
    m_full = 0; m_out = '0; m_ovf = 0; m_err = 0;
    for (int i = 0; i < 3000; i++) begin
      logic exp_rdy;
      logic [15:0] d;
      @(negedge clk);
      d = 16'($urandom);
      drive0($urandom_range(0, 3) != 0,
             ($urandom_range(0, 1) != 0) ? APND : 2'($urandom_range(0, 3)),
             d, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
      #1;
      check("rnd_out_valid", bus0.out_valid, m_full);
      if (m_full) begin
        check("rnd_out",      bus0.out, m_out);
        check("rnd_overflow", bus0.overflow, m_ovf);
        check("rnd_err",      bus0.err, m_err);
      end
      exp_rdy = !m_full || bus0.out_ready;
      check("rnd_in_ready", bus0.in_ready, exp_rdy);
      if (m_full && bus0.out_ready) m_full = 0;
      if (bus0.in_valid && exp_rdy) begin
        if (bus0.mode == APND) begin
          chq.push_back(bus0.in);
          if (bus0.last) begin
            int n, first;
            n = chq.size();
            first = (n > 2) ? n - 2 : 0;
            m_out = '0;
            for (int k = first; k < n; k++) m_out = {m_out[15:0], chq[k]};
            m_ovf = (n > 2);
            m_err = 0;
            m_full = 1;
            chq.delete();
          end
        end else begin
          m_err = (chq.size() > 0);
          m_ovf = 0;
          chq.delete();
          case (bus0.mode)
            ZEXT:    m_out = {16'h0000, bus0.in};
            SEXT:    m_out = {{16{bus0.in[15]}}, bus0.in};
            default: m_out = {bus0.in, 16'h0000};
          endcase
          m_full = 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
